// File: rtl/trace_port_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : trace_port_serializer_if
//  Description : Record-side trace port between trace_port_serializer and the
//                debug/trace subsystem. One instruction record per handshake,
//                plus the sticky overflow status.
//  Revision    : 1.0  initial release
// ============================================================================
interface trace_port_serializer_if;
    logic        tr_valid;
    logic        tr_ready;
    logic [1:0]  tr_lane;
    logic [31:0] tr_insn;
    logic [31:0] tr_addr;
    logic        tr_exc;
    logic        tr_intr;
    logic [4:0]  tr_ecause;
    logic [31:0] tr_tval;
    logic        tr_last;
    logic        tr_ovf;
    logic [15:0] tr_drop_cnt;

    // Serializer side: produces records, observes sink readiness.
    modport master (
        output tr_valid, tr_lane, tr_insn, tr_addr, tr_exc, tr_intr,
               tr_ecause, tr_tval, tr_last, tr_ovf, tr_drop_cnt,
        input  tr_ready
    );

    // Trace sink side: consumes records, drives readiness.
    modport slave (
        input  tr_valid, tr_lane, tr_insn, tr_addr, tr_exc, tr_intr,
               tr_ecause, tr_tval, tr_last, tr_ovf, tr_drop_cnt,
        output tr_ready
    );
endinterface
`default_nettype wire

// File: rtl/trace_port_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : trace_port_serializer
//  Description : Captures non-empty 3-lane retire packets from the core into a
//                DEPTH-entry FIFO and replays the valid lanes one record at a
//                time on a valid/ready trace port. Packets arriving while the
//                FIFO is full (and the head is not retiring) are dropped and
//                flagged on the sticky tr_ovf.
//                Optional feature macro: RV_TRACE_DROP_CNT_EN builds the
//                saturating 16-bit dropped-packet counter on tr_drop_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
module trace_port_serializer #(
    parameter int DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_l,
    input  wire logic [2:0]  trace_rv_i_valid_ip,
    input  wire logic [95:0] trace_rv_i_insn_ip,
    input  wire logic [95:0] trace_rv_i_address_ip,
    input  wire logic [2:0]  trace_rv_i_exception_ip,
    input  wire logic [2:0]  trace_rv_i_interrupt_ip,
    input  wire logic [4:0]  trace_rv_i_ecause_ip,
    input  wire logic [31:0] trace_rv_i_tval_ip,
    input  wire logic        trace_clr,
    trace_port_serializer_if.master tr_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Packet storage (data only; emptiness is tracked by cnt_q)
    logic [2:0]  mem_valid_q [DEPTH];
    logic [95:0] mem_insn_q  [DEPTH];
    logic [95:0] mem_addr_q  [DEPTH];
    logic [2:0]  mem_exc_q   [DEPTH];
    logic [2:0]  mem_intr_q  [DEPTH];
    logic [4:0]  mem_ecause_q[DEPTH];
    logic [31:0] mem_tval_q  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    done_q, done_d;   // lanes of the head packet already sent
    logic          ovf_q, ovf_d;

    logic          empty, full, hs, pop, push_req, push, drop;
    logic [2:0]    rem, rem_low;
    logic [1:0]    lane;
    logic          last;
    logic [31:0]   insn_sel, addr_sel;
    logic          exc_sel, intr_sel;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign rem      = mem_valid_q[rd_ptr_q] & ~done_q;
    assign rem_low  = rem & (~rem + 3'd1);
    assign last     = (rem != 3'd0) && ((rem & (rem - 3'd1)) == 3'd0);
    assign hs       = !empty && tr_if.tr_ready;
    assign pop      = hs && last;
    assign push_req = (trace_rv_i_valid_ip != 3'd0);
    // A full FIFO still accepts when the head vacates its slot this cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && !push;

    // Head lane selection: lowest lane still pending in the head packet
    always_comb begin
        lane = 2'd2;
        if (rem[0])      lane = 2'd0;
        else if (rem[1]) lane = 2'd1;
        insn_sel = '0;
        addr_sel = '0;
        exc_sel  = 1'b0;
        intr_sel = 1'b0;
        case (lane)
            2'd0: begin
                insn_sel = mem_insn_q[rd_ptr_q][31:0];
                addr_sel = mem_addr_q[rd_ptr_q][31:0];
                exc_sel  = mem_exc_q[rd_ptr_q][0];
                intr_sel = mem_intr_q[rd_ptr_q][0];
            end
            2'd1: begin
                insn_sel = mem_insn_q[rd_ptr_q][63:32];
                addr_sel = mem_addr_q[rd_ptr_q][63:32];
                exc_sel  = mem_exc_q[rd_ptr_q][1];
                intr_sel = mem_intr_q[rd_ptr_q][1];
            end
            default: begin
                insn_sel = mem_insn_q[rd_ptr_q][95:64];
                addr_sel = mem_addr_q[rd_ptr_q][95:64];
                exc_sel  = mem_exc_q[rd_ptr_q][2];
                intr_sel = mem_intr_q[rd_ptr_q][2];
            end
        endcase
    end

    // Output record: everything derives from flops, so it holds under stall
    always_comb begin
        tr_if.tr_valid  = !empty;
        tr_if.tr_lane   = '0;
        tr_if.tr_insn   = '0;
        tr_if.tr_addr   = '0;
        tr_if.tr_exc    = 1'b0;
        tr_if.tr_intr   = 1'b0;
        tr_if.tr_ecause = '0;
        tr_if.tr_tval   = '0;
        tr_if.tr_last   = 1'b0;
        if (!empty) begin
            tr_if.tr_lane = lane;
            tr_if.tr_insn = insn_sel;
            tr_if.tr_addr = addr_sel;
            tr_if.tr_exc  = exc_sel;
            tr_if.tr_intr = intr_sel;
            tr_if.tr_last = last;
            if (exc_sel || intr_sel) begin
                tr_if.tr_ecause = mem_ecause_q[rd_ptr_q];
                tr_if.tr_tval   = mem_tval_q[rd_ptr_q];
            end
        end
    end
    assign tr_if.tr_ovf = ovf_q;

    // Next-state for pointers, occupancy, head lane progress and overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        if (trace_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            done_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            // Clearing done on pop makes the next entry start with its full mask.
            if (pop)     done_d = '0;
            else if (hs) done_d = done_q | rem_low;
            if (drop) ovf_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            done_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // Packet storage write; unread slots are masked by occupancy so no reset
    always_ff @(posedge clk) begin
        if (push && !trace_clr) begin
            mem_valid_q [wr_ptr_q] <= trace_rv_i_valid_ip;
            mem_insn_q  [wr_ptr_q] <= trace_rv_i_insn_ip;
            mem_addr_q  [wr_ptr_q] <= trace_rv_i_address_ip;
            mem_exc_q   [wr_ptr_q] <= trace_rv_i_exception_ip;
            mem_intr_q  [wr_ptr_q] <= trace_rv_i_interrupt_ip;
            mem_ecause_q[wr_ptr_q] <= trace_rv_i_ecause_ip;
            mem_tval_q  [wr_ptr_q] <= trace_rv_i_tval_ip;
        end
    end

`ifdef RV_TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating dropped-packet counter
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (trace_clr)
            drop_cnt_d = '0;
        else if (drop && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Drop counter register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign tr_if.tr_drop_cnt = drop_cnt_q;
`else
    assign tr_if.tr_drop_cnt = '0;
`endif

endmodule
`default_nettype wire
